// File: rtl/frag_mem_pkg.sv
// Shared types and helpers for the fragment memory client.
// Fragments are 256-byte blocks. The low 8 address bits are the byte offset
// within a fragment, and the upper bits are the fragment index.
package frag_mem_pkg;

    localparam int AW_DEF     = 16;
    localparam int OFS_W      = 8;
    localparam int FRAG_BYTES = 256;
    localparam int IDX_W      = AW_DEF - OFS_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        RD_HOLD = 2'd3
    } state_t;

    // Byte address of the first byte of fragment idx.
    function automatic logic [AW_DEF-1:0] frag_base(input logic [IDX_W-1:0] idx);
        return {idx, {OFS_W{1'b0}}};
    endfunction

endpackage

// File: rtl/frag_wr_addr_gen.sv
// Write byte pointer for the fragment memory client.
// The pointer can be loaded with a fragment base address and advances by one
// for each accepted byte. It wraps naturally at 2^AW.
// The addr output is the address the current byte must use. When a load and a
// byte arrive in the same cycle, addr is already the freshly loaded base.
module frag_wr_addr_gen
    import frag_mem_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic [AW-8-1:0]   load_frag,
    input  logic              inc,
    output logic [AW-1:0]     addr
);

    logic [AW-1:0] ptr_r;
    logic [AW-1:0] base_s;

    assign base_s = frag_base(load_frag);

    // The effective address for this cycle: a load overrides the stored pointer.
    always_comb begin
        addr = ptr_r;
        if (load) begin
            addr = base_s;
        end else begin
            addr = ptr_r;
        end
    end

    // Pointer update: advance past the byte just written, otherwise follow a load.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_r <= {AW{1'b0}};
        end else if (inc) begin
            ptr_r <= addr + {{(AW-1){1'b0}}, 1'b1};
        end else if (load) begin
            ptr_r <= base_s;
        end
    end

endmodule

// File: rtl/frag_mem_client.sv
// Initiator-side controller for the fragment memory.
// Upstream bytes become single-byte writes at auto-incrementing addresses.
// Fragment read commands become fragment-aligned read requests. The returned
// fragment is captured and offered downstream with a valid/ready handshake.
// If the memory does not answer a read within TIMEOUT cycles, the read is
// abandoned and the sticky err flag is raised.
module frag_mem_client
    import frag_mem_pkg::*;
#(
    parameter int AW         = 16,
    parameter int BYTE       = 8,
    parameter int FRAG_BYTES = 256,
    parameter int TIMEOUT    = 15
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       wr_start,
    input  logic [AW-8-1:0]            wr_frag,
    input  logic                       s_valid,
    input  logic [BYTE-1:0]            s_data,
    output logic                       s_ready,
    input  logic                       rd_valid,
    input  logic [AW-8-1:0]            rd_frag,
    output logic                       rd_ready,
    output logic                       m_valid,
    output logic [BYTE*FRAG_BYTES-1:0] m_data,
    input  logic                       m_ready,
    output logic                       err,
    output logic                       mem_wnr,
    output logic                       mem_req,
    output logic [BYTE-1:0]            mem_data,
    output logic [AW-1:0]              mem_addr,
    input  logic [BYTE*FRAG_BYTES-1:0] mem_rdata,
    input  logic                       mem_ready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             s_acc_s;
    logic             rd_acc_s;
    logic [AW-1:0]    wr_addr_s;

    // Handshakes are decoded from state. A pending byte blocks a read command.
    assign s_ready  = (state_r == IDLE);
    assign rd_ready = (state_r == IDLE) && !s_valid;
    assign s_acc_s  = s_valid && s_ready;
    assign rd_acc_s = rd_valid && rd_ready;

    frag_wr_addr_gen #(
        .AW (AW)
    ) u_wr_addr (
        .clk       (clk),
        .rstn      (rstn),
        .load      (wr_start),
        .load_frag (wr_frag),
        .inc       (s_acc_s),
        .addr      (wr_addr_s)
    );

    // Main FSM: issues memory requests, times out reads, captures and hands off fragments.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            mem_req  <= 1'b0;
            mem_wnr  <= 1'b0;
            mem_data <= {BYTE{1'b0}};
            mem_addr <= {AW{1'b0}};
            m_valid  <= 1'b0;
            m_data   <= {(BYTE*FRAG_BYTES){1'b0}};
            err      <= 1'b0;
        end else begin
            // Requests are single-cycle pulses; the address and data lines hold their values.
            mem_req <= 1'b0;
            if (wr_start) begin
                err <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (s_acc_s) begin
                        mem_req  <= 1'b1;
                        mem_wnr  <= 1'b1;
                        mem_data <= s_data;
                        mem_addr <= wr_addr_s;
                    end else if (rd_acc_s) begin
                        // The read request goes out while the FSM sits in RD_REQ.
                        mem_req  <= 1'b1;
                        mem_wnr  <= 1'b0;
                        mem_addr <= frag_base(rd_frag);
                        state_r  <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= RD_WAIT;
                end
                RD_WAIT: begin
                    // A reply that arrives on the last allowed cycle still wins over the timeout.
                    if (mem_ready) begin
                        m_data  <= mem_rdata;
                        m_valid <= 1'b1;
                        state_r <= RD_HOLD;
                    end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                        err     <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                RD_HOLD: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    m_valid <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
